// File: rtl/jk_bank.sv
// -----------------------------------------------------------------------------
// jk_bank
//
// Purpose:
//   A bank of WIDTH JK flip-flops that can also behave as a single up/down
//   counter or a parallel load register. The operation is chosen by mode:
//     00 JK   - each bit follows its own (J,K) pair: hold/clear/set/toggle
//     01 UP   - Q increments, wrapping or saturating at all-ones
//     10 DOWN - Q decrements, wrapping or saturating at zero
//     11 LOAD - Q takes the value on J
//   Three registered status flags report what the last edge did.
//
// Parameters:
//   WIDTH   - number of JK cells (>= 2)
//   RST_VAL - value Q takes on reset
//   SAT     - 1 = counts stop at their limit, 0 = counts wrap around
//
// Ports:
//   clk   in   clock, all state changes on the rising edge
//   n_rst in   synchronous active-low reset
//   en    in   operation enable; 0 holds Q and clears the flags
//   mode  in   operation select (see above)
//   J     in   per-bit J inputs in JK mode, load data in LOAD mode
//   K     in   per-bit K inputs in JK mode, ignored otherwise
//   Q     out  registered bank state
//   wrap  out  one-cycle flag: a count crossed its boundary
//   sat   out  one-cycle flag: a count was held at its limit
//   chg   out  Q changed on the last edge
// -----------------------------------------------------------------------------
module jk_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
    output logic             sat,
    output logic             chg
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q,    q_d;
    logic             wrap_q, wrap_d;
    logic             sat_q,  sat_d;
    logic             chg_q,  chg_d;
    mode_e            op;

    assign op = mode_e'(mode);

    // Next-state logic. Flags default to 0 so that every operation which is
    // not a count hitting its limit (including en=0) clears them.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (en) begin
            case (op)
                // Characteristic JK equation: set where J=1 and Q=0, keep
                // where K=0 and Q=1; J=K=1 therefore toggles.
                MODE_JK: q_d = (J & ~q_q) | (~K & q_q);
                MODE_UP: begin
                    if (q_q == ALL_ONES) begin
                        if (SAT) begin
                            sat_d = 1'b1;
                        end else begin
                            q_d    = ZERO;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        q_d = q_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q_q == ZERO) begin
                        if (SAT) begin
                            sat_d = 1'b1;
                        end else begin
                            q_d    = ALL_ONES;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                MODE_LOAD: q_d = J;
                default:   q_d = q_q;
            endcase
        end
        // A saturated count holds Q, so sat and chg can never coincide.
        chg_d = (q_d != q_q);
    end

    // State register; reset is sampled only on the clock edge and wins
    // over every operation.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q_q    <= RST_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
            chg_q  <= chg_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_jk_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_bank
//
// Self-checking bench for jk_bank with WIDTH=4. Three instances share one
// set of stimulus inputs:
//   dutWrap : SAT=0, RST_VAL=0
//   dutSat  : SAT=1, RST_VAL=0
//   dutRst  : SAT=0, RST_VAL=4'hA
// Each test task drives vectors and compares outputs against hand-computed
// values one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_jk_bank;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] J;
    logic [3:0] K;

    logic [3:0] qW, qS, qR;
    logic       wrapW, satW, chgW;
    logic       wrapS, satS, chgS;
    logic       wrapR, satR, chgR;

    int checkCount = 0;
    int failCount  = 0;

    jk_bank #(.WIDTH(4), .RST_VAL(4'h0), .SAT(1'b0)) dutWrap (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .J(J), .K(K),
        .Q(qW), .wrap(wrapW), .sat(satW), .chg(chgW)
    );

    jk_bank #(.WIDTH(4), .RST_VAL(4'h0), .SAT(1'b1)) dutSat (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .J(J), .K(K),
        .Q(qS), .wrap(wrapS), .sat(satS), .chg(chgS)
    );

    jk_bank #(.WIDTH(4), .RST_VAL(4'hA), .SAT(1'b0)) dutRst (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .J(J), .K(K),
        .Q(qR), .wrap(wrapR), .sat(satR), .chg(chgR)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and advances past the next rising edge so the
    // registered result can be sampled.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [3:0] j, input logic [3:0] k);
        n_rst = r;
        en    = e;
        mode  = m;
        J     = j;
        K     = k;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        applyStimulus(1'b0, 1'b1, 2'b01, 4'hF, 4'hF);
        checkCount++;
        if (qW !== 4'h0) begin failCount++; $display("[TB] FAIL reset_qW got=%h exp=%h", qW, 4'h0); end
        checkCount++;
        if (qR !== 4'hA) begin failCount++; $display("[TB] FAIL reset_qR got=%h exp=%h", qR, 4'hA); end
        checkCount++;
        if ({wrapW, satW, chgW, wrapS, satS, chgS} !== 6'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags got=%b exp=%b", {wrapW, satW, chgW, wrapS, satS, chgS}, 6'b0);
        end
    endtask

    task automatic test_jk;
        // From 0000: bit0 toggle, bit1 set, bit2 clear, bit3 hold -> 0011
        applyStimulus(1'b1, 1'b1, 2'b00, 4'b0011, 4'b0101);
        checkCount++;
        if (qW !== 4'b0011) begin failCount++; $display("[TB] FAIL jk_first got=%b exp=%b", qW, 4'b0011); end
        checkCount++;
        if ({chgW, wrapW, satW} !== 3'b100) begin failCount++; $display("[TB] FAIL jk_first_flags got=%b exp=%b", {chgW, wrapW, satW}, 3'b100); end
        // Same J/K from 0011: bit0 toggles back to 0, bit1 stays set -> 0010
        applyStimulus(1'b1, 1'b1, 2'b00, 4'b0011, 4'b0101);
        checkCount++;
        if (qW !== 4'b0010) begin failCount++; $display("[TB] FAIL jk_second got=%b exp=%b", qW, 4'b0010); end
        // All toggle -> 1101
        applyStimulus(1'b1, 1'b1, 2'b00, 4'b1111, 4'b1111);
        checkCount++;
        if (qW !== 4'b1101) begin failCount++; $display("[TB] FAIL jk_toggle got=%b exp=%b", qW, 4'b1101); end
        // All hold -> unchanged, chg drops
        applyStimulus(1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000);
        checkCount++;
        if ({qW, chgW} !== {4'b1101, 1'b0}) begin failCount++; $display("[TB] FAIL jk_hold got=%b/%b exp=%b/%b", qW, chgW, 4'b1101, 1'b0); end
    endtask

    task automatic test_wrap_count;
        applyStimulus(1'b1, 1'b1, 2'b11, 4'hE, 4'h0);
        checkCount++;
        if ({qW, chgW} !== {4'hE, 1'b1}) begin failCount++; $display("[TB] FAIL load_e got=%h/%b exp=%h/%b", qW, chgW, 4'hE, 1'b1); end
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, wrapW} !== {4'hF, 1'b0}) begin failCount++; $display("[TB] FAIL up_to_f got=%h/%b exp=%h/%b", qW, wrapW, 4'hF, 1'b0); end
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, wrapW, chgW, satW} !== {4'h0, 3'b110}) begin
            failCount++;
            $display("[TB] FAIL up_wrap got=%h/%b exp=%h/%b", qW, {wrapW, chgW, satW}, 4'h0, 3'b110);
        end
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, wrapW} !== {4'h1, 1'b0}) begin failCount++; $display("[TB] FAIL up_to_1 got=%h/%b exp=%h/%b", qW, wrapW, 4'h1, 1'b0); end
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        checkCount++;
        if ({qW, wrapW, chgW} !== {4'hF, 2'b11}) begin failCount++; $display("[TB] FAIL down_wrap got=%h/%b exp=%h/%b", qW, {wrapW, chgW}, 4'hF, 2'b11); end
        applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        checkCount++;
        if ({qW, wrapW} !== {4'hE, 1'b0}) begin failCount++; $display("[TB] FAIL down_plain got=%h/%b exp=%h/%b", qW, wrapW, 4'hE, 1'b0); end
    endtask

    task automatic test_saturate;
        applyStimulus(1'b1, 1'b1, 2'b11, 4'hF, 4'h0);
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qS, satS, chgS, wrapS} !== {4'hF, 3'b100}) begin
            failCount++;
            $display("[TB] FAIL sat_up got=%h/%b exp=%h/%b", qS, {satS, chgS, wrapS}, 4'hF, 3'b100);
        end
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h0, 4'h0);
        checkCount++;
        if (satS !== 1'b0) begin failCount++; $display("[TB] FAIL sat_clear_on_load got=%b exp=%b", satS, 1'b0); end
        applyStimulus(1'b1, 1'b1, 2'b10, 4'h0, 4'h0);
        checkCount++;
        if ({qS, satS, chgS, wrapS} !== {4'h0, 3'b100}) begin
            failCount++;
            $display("[TB] FAIL sat_down got=%h/%b exp=%h/%b", qS, {satS, chgS, wrapS}, 4'h0, 3'b100);
        end
    endtask

    task automatic test_enable_hold;
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h7, 4'h0);
        checkCount++;
        if ({qW, chgW} !== {4'h7, 1'b1}) begin failCount++; $display("[TB] FAIL load_7 got=%h/%b exp=%h/%b", qW, chgW, 4'h7, 1'b1); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b01, 4'($urandom_range(15)), 4'($urandom_range(15)));
            checkCount++;
            if ({qW, wrapW, satW, chgW} !== {4'h7, 3'b000}) begin
                failCount++;
                $display("[TB] FAIL en_hold_%0d got=%h/%b exp=%h/%b", i, qW, {wrapW, satW, chgW}, 4'h7, 3'b000);
            end
        end
        // Reloading the same value is not a change
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h7, 4'h0);
        checkCount++;
        if (chgW !== 1'b0) begin failCount++; $display("[TB] FAIL load_same_chg got=%b exp=%b", chgW, 1'b0); end
    endtask

    task automatic test_reset_mid_count;
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h5, 4'h0);
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, qR} !== {4'h6, 4'h6}) begin failCount++; $display("[TB] FAIL count_6 got=%h%h exp=%h%h", qW, qR, 4'h6, 4'h6); end
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, qR, chgW, chgR} !== {4'h0, 4'hA, 2'b00}) begin
            failCount++;
            $display("[TB] FAIL mid_reset got=%h%h/%b exp=%h%h/%b", qW, qR, {chgW, chgR}, 4'h0, 4'hA, 2'b00);
        end
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'h0);
        checkCount++;
        if ({qW, qR} !== {4'h1, 4'hB}) begin failCount++; $display("[TB] FAIL after_release got=%h%h exp=%h%h", qW, qR, 4'h1, 4'hB); end
    endtask

    task automatic test_short_reset_pulse;
        applyStimulus(1'b1, 1'b1, 2'b11, 4'h9, 4'h0);
        en = 1'b0;
        // Pulse lies entirely between edges (edge at t, pulse t+2..t+5)
        #1 n_rst = 1'b0;
        #3 n_rst = 1'b1;
        checkCount++;
        if ({qW, qR} !== {4'h9, 4'h9}) begin failCount++; $display("[TB] FAIL pulse_mid got=%h%h exp=%h%h", qW, qR, 4'h9, 4'h9); end
        @(posedge clk);
        #1;
        checkCount++;
        if ({qW, qR} !== {4'h9, 4'h9}) begin failCount++; $display("[TB] FAIL pulse_after got=%h%h exp=%h%h", qW, qR, 4'h9, 4'h9); end
    endtask

    initial begin
        n_rst = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        J     = 4'h0;
        K     = 4'h0;
        test_reset();
        test_jk();
        test_reset();
        test_wrap_count();
        test_reset();
        test_saturate();
        test_enable_hold();
        test_reset();
        test_reset_mid_count();
        test_short_reset_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
